riot_6532: RTL and testbench

RAM-I/O-Timer (6532 RIOT) peripheral that sits directly downstream of the MOS6507 CPU wrapper on the 13-bit bus. It decodes the CPU address, provides 128 bytes of scratch RAM, two 8-bit I/O ports and the programmable interval timer, and returns read data to the CPU data-in bus.

---
 rtl/riot_6532_if.sv | 11 +
 rtl/riot_6532.sv | 206 ++++++++++++++++++++
 tb/tb_riot_6532.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/riot_6532_if.sv
// CPU-side bus of the 6532 RIOT: address, direction, write data and read data.
// The CPU wrapper uses the master view; the RIOT uses the slave view.
interface riot_6532_if;
    logic [12:0] A;
    logic        R_W_n;
    logic [7:0]  Din;
    logic [7:0]  Dout;

    modport master (output A, output R_W_n, output Din, input Dout);
    modport slave  (input A, input R_W_n, input Din, output Dout);
endinterface

// File: rtl/riot_6532.sv
// 6532 RIOT: 128-byte scratch RAM, two 8-bit I/O ports with direction registers,
// PA7 edge detector and the programmable interval timer, on the console address map.
module riot_6532 (
    input  logic        CLK_n,
    input  logic        RES_n,
    riot_6532_if.slave  bus,
    input  logic [7:0]  PA_in,
    input  logic [7:0]  PB_in,
    output logic [7:0]  PA_out,
    output logic [7:0]  PB_out,
    output logic [7:0]  PA_oe,
    output logic [7:0]  PB_oe,
    output logic        IRQ_n
);
    logic [12:0] addr;
    logic        sel, rd, wr;
    logic        tc_sel, io_sel;
    logic        tim_wr, ctl_wr, tim_rd, flg_rd;
    logic        unused_addr_bits;

    assign addr   = bus.A;
    assign sel    = ~addr[12] & addr[7];
    assign rd     = sel & bus.R_W_n;
    assign wr     = sel & ~bus.R_W_n;
    assign io_sel = addr[9] & ~addr[2];
    assign tc_sel = addr[9] & addr[2];
    assign tim_wr = wr & tc_sel & addr[4];
    assign ctl_wr = wr & tc_sel & ~addr[4];
    assign tim_rd = rd & tc_sel & ~addr[0];
    assign flg_rd = rd & tc_sel & addr[0];
    assign unused_addr_bits = ^{addr[11:10], addr[8]};

    // Port, synchronizer and control state
    logic [7:0] ora_reg, ddra_reg, orb_reg, ddrb_reg;
    logic [7:0] pa_sync1_reg, pa_sync2_reg, pb_sync1_reg, pb_sync2_reg;
    logic       pa7_prev_reg;
    logic       pflag_reg, pflag_next;
    logic       pie_reg, edge_rise_reg;
    logic       pa7_edge;

    // Timer state
    logic [7:0] timer_reg, timer_next;
    logic [9:0] presc_reg, presc_next;
    logic [1:0] div_sel_reg, div_sel_next;
    logic       expired_reg, expired_next;
    logic       tflag_reg, tflag_next;
    logic       tie_reg, tie_next;
    logic       timer_tick, timer_wrap;

    // Read path
    logic [7:0] pa_rd, pb_rd, rd_mux;
    logic [7:0] rd_data_reg;
    logic       rd_src_ram_reg;
    logic [7:0] ram [0:127];
    logic [7:0] ram_q_reg;

    function automatic logic [9:0] reload_val(input logic [1:0] s);
        case (s)
            2'b00:   reload_val = 10'd0;
            2'b01:   reload_val = 10'd7;
            2'b10:   reload_val = 10'd63;
            default: reload_val = 10'd1023;
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_port_rd
            assign pa_rd[gi] = ddra_reg[gi] ? ora_reg[gi] : pa_sync2_reg[gi];
            assign pb_rd[gi] = ddrb_reg[gi] ? orb_reg[gi] : pb_sync2_reg[gi];
        end
    endgenerate

    always_comb begin
        rd_mux = 8'h00;
        if (tc_sel) begin
            rd_mux = addr[0] ? {tflag_reg, pflag_reg, 6'b000000} : timer_reg;
        end else begin
            case (addr[1:0])
                2'b00:   rd_mux = pa_rd;
                2'b01:   rd_mux = ddra_reg;
                2'b10:   rd_mux = pb_rd;
                default: rd_mux = ddrb_reg;
            endcase
        end
    end

    // Expiry sets the flag even on a timer read edge; a timer write overrides both.
    always_comb begin
        timer_tick   = expired_reg | (presc_reg == 10'd0);
        timer_wrap   = timer_tick & (timer_reg == 8'h00);
        timer_next   = timer_reg;
        presc_next   = presc_reg;
        div_sel_next = div_sel_reg;
        expired_next = expired_reg;
        tflag_next   = tflag_reg;
        tie_next     = tie_reg;
        if (tim_wr) begin
            timer_next   = bus.Din;
            div_sel_next = addr[1:0];
            presc_next   = reload_val(addr[1:0]);
            expired_next = 1'b0;
            tflag_next   = 1'b0;
            tie_next     = addr[3];
        end else begin
            presc_next = (presc_reg == 10'd0) ? reload_val(div_sel_reg) : presc_reg - 10'd1;
            if (timer_tick) begin
                timer_next = timer_reg - 8'd1;
            end
            if (timer_wrap) begin
                tflag_next   = 1'b1;
                expired_next = 1'b1;
            end else if (tim_rd) begin
                tflag_next = 1'b0;
            end
            if (tim_rd) begin
                tie_next = addr[3];
            end
        end
    end

    always_comb begin
        pa7_edge = edge_rise_reg ? (pa_sync2_reg[7] & ~pa7_prev_reg)
                                 : (~pa_sync2_reg[7] & pa7_prev_reg);
        pflag_next = pflag_reg;
        if (pa7_edge) begin
            pflag_next = 1'b1;
        end else if (flg_rd) begin
            pflag_next = 1'b0;
        end
    end

    always_ff @(posedge CLK_n or negedge RES_n) begin
        if (!RES_n) begin
            ora_reg        <= 8'h00;
            ddra_reg       <= 8'h00;
            orb_reg        <= 8'h00;
            ddrb_reg       <= 8'h00;
            pa_sync1_reg   <= 8'h00;
            pa_sync2_reg   <= 8'h00;
            pb_sync1_reg   <= 8'h00;
            pb_sync2_reg   <= 8'h00;
            pa7_prev_reg   <= 1'b0;
            pflag_reg      <= 1'b0;
            pie_reg        <= 1'b0;
            edge_rise_reg  <= 1'b0;
            timer_reg      <= 8'h00;
            presc_reg      <= 10'd1023;
            div_sel_reg    <= 2'b11;
            expired_reg    <= 1'b0;
            tflag_reg      <= 1'b0;
            tie_reg        <= 1'b0;
            rd_data_reg    <= 8'h00;
            rd_src_ram_reg <= 1'b0;
        end else begin
            pa_sync1_reg <= PA_in;
            pa_sync2_reg <= pa_sync1_reg;
            pb_sync1_reg <= PB_in;
            pb_sync2_reg <= pb_sync1_reg;
            pa7_prev_reg <= pa_sync2_reg[7];
            pflag_reg    <= pflag_next;
            timer_reg    <= timer_next;
            presc_reg    <= presc_next;
            div_sel_reg  <= div_sel_next;
            expired_reg  <= expired_next;
            tflag_reg    <= tflag_next;
            tie_reg      <= tie_next;
            if (wr && io_sel) begin
                case (addr[1:0])
                    2'b00:   ora_reg  <= bus.Din;
                    2'b01:   ddra_reg <= bus.Din;
                    2'b10:   orb_reg  <= bus.Din;
                    default: ddrb_reg <= bus.Din;
                endcase
            end
            if (ctl_wr) begin
                edge_rise_reg <= addr[0];
                pie_reg       <= addr[1];
            end
            if (rd) begin
                rd_src_ram_reg <= ~addr[9];
                if (addr[9]) begin
                    rd_data_reg <= rd_mux;
                end
            end
        end
    end

    // RAM is deliberately left out of reset so it maps onto block RAM.
    always_ff @(posedge CLK_n) begin
        if (sel && !addr[9]) begin
            if (!bus.R_W_n) begin
                ram[addr[6:0]] <= bus.Din;
            end else begin
                ram_q_reg <= ram[addr[6:0]];
            end
        end
    end

    assign bus.Dout = rd_src_ram_reg ? ram_q_reg : rd_data_reg;
    assign PA_out   = ora_reg;
    assign PB_out   = orb_reg;
    assign PA_oe    = ddra_reg;
    assign PB_oe    = ddrb_reg;
    assign IRQ_n    = ~((tflag_reg & tie_reg) | (pflag_reg & pie_reg));
endmodule

// File: tb/tb_riot_6532.sv
// Directed bench for riot_6532: a vector table for RAM/port accesses plus
// hand-written sequences for timer, interrupt, PA7 edge and reset corner cases.
module tb_riot_6532;
    logic       CLK_n = 1'b0;
    logic       RES_n = 1'b0;
    logic [7:0] PA_in = 8'h0F;
    logic [7:0] PB_in = 8'h55;
    logic [7:0] PA_out, PB_out, PA_oe, PB_oe;
    logic       IRQ_n;

    riot_6532_if bus();

    riot_6532 dut (
        .CLK_n  (CLK_n),
        .RES_n  (RES_n),
        .bus    (bus),
        .PA_in  (PA_in),
        .PB_in  (PB_in),
        .PA_out (PA_out),
        .PB_out (PB_out),
        .PA_oe  (PA_oe),
        .PB_oe  (PB_oe),
        .IRQ_n  (IRQ_n)
    );

    always #5 CLK_n = ~CLK_n;

    typedef struct {
        bit          rw;
        logic [12:0] addr;
        logic [7:0]  data;
        bit          chk;
        logic [7:0]  exp;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end else begin
            $display("ok   %s: %02h", name, act);
        end
    endtask

    task automatic bus_op(input bit rw, input logic [12:0] a, input logic [7:0] d);
        @(negedge CLK_n);
        bus.A     = a;
        bus.R_W_n = rw;
        bus.Din   = d;
        @(posedge CLK_n);
        #1;
        bus.A     = 13'h0000;
        bus.R_W_n = 1'b1;
    endtask

    task automatic wr(input logic [12:0] a, input logic [7:0] d);
        bus_op(1'b0, a, d);
    endtask

    task automatic rd(input string name, input logic [12:0] a, input logic [7:0] exp);
        bus_op(1'b1, a, 8'h00);
        check(name, bus.Dout, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK_n);
        #1;
    endtask

    task automatic check_irq(input string name, input logic exp);
        check(name, {7'b0, IRQ_n}, {7'b0, exp});
    endtask

    initial begin
        bus.A     = 13'h0000;
        bus.R_W_n = 1'b1;
        bus.Din   = 8'h00;

        vecs.push_back('{1'b0, 13'h0080, 8'hA5, 1'b0, 8'h00, "ram_wr_80"});
        vecs.push_back('{1'b0, 13'h00FF, 8'h5A, 1'b0, 8'h00, "ram_wr_ff"});
        vecs.push_back('{1'b1, 13'h0080, 8'h00, 1'b1, 8'hA5, "ram_rd_80"});
        vecs.push_back('{1'b1, 13'h00FF, 8'h00, 1'b1, 8'h5A, "ram_rd_ff"});
        vecs.push_back('{1'b0, 13'h1080, 8'hFF, 1'b0, 8'h00, "ram_wr_a12"});
        vecs.push_back('{1'b1, 13'h0080, 8'h00, 1'b1, 8'hA5, "ram_a12_ignored"});
        vecs.push_back('{1'b0, 13'h0281, 8'hF0, 1'b0, 8'h00, "wr_ddra"});
        vecs.push_back('{1'b0, 13'h0280, 8'h3C, 1'b0, 8'h00, "wr_ora"});
        vecs.push_back('{1'b1, 13'h0280, 8'h00, 1'b1, 8'h3F, "rd_porta"});
        vecs.push_back('{1'b1, 13'h0281, 8'h00, 1'b1, 8'hF0, "rd_ddra"});
        vecs.push_back('{1'b0, 13'h0283, 8'h0F, 1'b0, 8'h00, "wr_ddrb"});
        vecs.push_back('{1'b0, 13'h0282, 8'hA0, 1'b0, 8'h00, "wr_orb"});
        vecs.push_back('{1'b1, 13'h0282, 8'h00, 1'b1, 8'h50, "rd_portb"});
        vecs.push_back('{1'b1, 13'h0283, 8'h00, 1'b1, 8'h0F, "rd_ddrb"});
        vecs.push_back('{1'b1, 13'h0000, 8'h00, 1'b1, 8'h0F, "dout_hold_a7"});
        vecs.push_back('{1'b1, 13'h1283, 8'h00, 1'b1, 8'h0F, "dout_hold_a12"});

        // Power-on reset
        #12;
        check("rst_dout", bus.Dout, 8'h00);
        check_irq("rst_irq_n", 1'b1);
        check("rst_pa_out", PA_out, 8'h00);
        check("rst_pa_oe", PA_oe, 8'h00);
        @(negedge CLK_n);
        RES_n = 1'b1;
        rd("rst_timer_rd", 13'h0284, 8'h00);

        foreach (vecs[i]) begin
            bus_op(vecs[i].rw, vecs[i].addr, vecs[i].data);
            if (vecs[i].chk) check(vecs[i].name, bus.Dout, vecs[i].exp);
            else $display("     %s: A=%03h D=%02h", vecs[i].name, vecs[i].addr, vecs[i].data);
        end
        check("pa_out", PA_out, 8'h3C);
        check("pa_oe", PA_oe, 8'hF0);
        check("pb_out", PB_out, 8'hA0);
        check("pb_oe", PB_oe, 8'h0F);

        // Timer /8 loaded with 3: decrements at edges 8,16,24, wraps at 32
        wr(13'h0295, 8'h03);
        for (int k = 1; k <= 8; k++) rd($sformatf("t8_hold_e%0d", k), 13'h0284, 8'h03);
        rd("t8_e9", 13'h0284, 8'h02);
        idle(21);
        rd("t8_e31", 13'h0284, 8'h00);
        rd("t8_e32_rd_at_wrap", 13'h0284, 8'h00);
        rd("t8_flag_survives_rd", 13'h0285, 8'h80);
        check_irq("t8_irq_disabled", 1'b1);
        rd("t8_expired_e34", 13'h0284, 8'hFE);
        rd("t8_expired_e35", 13'h0284, 8'hFD);
        rd("t8_flag_cleared", 13'h0285, 8'h00);

        // Timer /1 with IRQ enabled
        wr(13'h029C, 8'h00);
        check_irq("t1_irq_before", 1'b1);
        idle(1);
        check_irq("t1_irq_set", 1'b0);
        rd("t1_rd_ff", 13'h028C, 8'hFF);
        check_irq("t1_irq_cleared", 1'b1);
        rd("t1_rd_fe", 13'h028C, 8'hFE);
        rd("t1_rd_fd", 13'h028C, 8'hFD);

        // Timer write on the expiry edge wins
        wr(13'h029C, 8'h00);
        wr(13'h029C, 8'h05);
        check_irq("wr_wins_irq", 1'b1);
        rd("wr_wins_t05", 13'h028C, 8'h05);
        rd("wr_wins_t04", 13'h028C, 8'h04);
        wr(13'h0297, 8'h00);

        // PA7 rising edge with IRQ enabled
        rd("pa7_flag_idle", 13'h0285, 8'h00);
        wr(13'h0287, 8'h00);
        PA_in = 8'h8F;
        idle(2);
        check_irq("pa7_not_yet", 1'b1);
        idle(1);
        check_irq("pa7_irq_set", 1'b0);
        rd("pa7_flag_rd", 13'h0285, 8'h40);
        check_irq("pa7_irq_cleared", 1'b1);
        rd("pa7_flag_rd2", 13'h0285, 8'h00);

        // Falling edge landing on a flag-register read edge
        wr(13'h0286, 8'h00);
        PA_in = 8'h0F;
        idle(2);
        rd("pa7_fall_coincide", 13'h0285, 8'h00);
        check_irq("pa7_fall_irq", 1'b0);
        rd("pa7_fall_flag", 13'h0285, 8'h40);

        // Arm a pending PA7 interrupt, then reset mid-countdown
        PA_in = 8'h8F;
        idle(4);
        PA_in = 8'h0F;
        idle(4);
        check_irq("pre_rst_irq", 1'b0);
        wr(13'h0295, 8'h50);
        idle(20);
        rd("pre_rst_timer", 13'h0284, 8'h4E);
        #2;
        RES_n = 1'b0;
        #1;
        check("mid_rst_dout", bus.Dout, 8'h00);
        check_irq("mid_rst_irq_n", 1'b1);
        check("mid_rst_pa_out", PA_out, 8'h00);
        check("mid_rst_pa_oe", PA_oe, 8'h00);
        check("mid_rst_pb_out", PB_out, 8'h00);
        check("mid_rst_pb_oe", PB_oe, 8'h00);
        @(negedge CLK_n);
        RES_n = 1'b1;
        rd("post_rst_timer", 13'h0284, 8'h00);
        rd("post_rst_flags", 13'h0285, 8'h00);
        rd("post_rst_ddra", 13'h0281, 8'h00);
        rd("post_rst_ram_kept", 13'h0080, 8'hA5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
